reg_file_param: RTL
===================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the register width in bits; it must be a multiple of 8.
REQ-002 The module SHALL have parameter ADDR_W, default 4, giving the address width; the register count is DEPTH = 2**ADDR_W.
REQ-003 The module SHALL have parameter NUM_RD, default 2, giving the number of read ports (1..4).
REQ-004 The module SHALL have parameter ZERO_REG, default 0; when set to 1, register 0 is hardwired to zero.
REQ-005 The module SHALL have parameter BYPASS, default 1; when set to 1, write-to-read forwarding happens in the same cycle.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port wr_en, input, 1 bit: write strobe.
REQ-009 The module SHALL have port write_addr, input, ADDR_W bits: the write target.
REQ-010 The module SHALL have port write_data, input, DATA_W bits: the write value.
REQ-011 The module SHALL have port write_be, input, DATA_W/8 bits: byte enables; bit i covers write_data[8i+7:8i].
REQ-012 The module SHALL have port read_addr, input, NUM_RD*ADDR_W bits: packed read addresses, with port k at [k*ADDR_W +: ADDR_W].
REQ-013 The module SHALL have port read_data, output, NUM_RD*DATA_W bits: packed read data, with port k at [k*DATA_W +: DATA_W].
REQ-014 The module SHALL have port rsv_en, input, 1 bit: reserve strobe; marks a register as pending a future write.
REQ-015 The module SHALL have port rsv_addr, input, ADDR_W bits: the register to reserve.
REQ-016 The module SHALL have port read_pending, output, NUM_RD bits: bit k is the pending flag of read_addr port k.

Function
REQ-017 The design SHALL hold DEPTH registers of DATA_W bits plus one DEPTH-bit pending vector.
REQ-018 Reads SHALL be combinational, with zero-cycle latency: read_data port k equals reg[read_addr k] in the same cycle.
REQ-019 A write SHALL occur at the rising clk edge when wr_en=1 and reset=0.
- Each byte i with write_be[i]=1 takes write_data byte i.
- Each byte with write_be[i]=0 keeps its old value.
REQ-020 When wr_en=1 and write_be is all zero, the design SHALL leave data unchanged but still clear the pending flag.
REQ-021 When BYPASS=1, wr_en=1 and read_addr k equals write_addr, read_data port k SHALL return the byte-merged value that will be stored, in the same cycle.
REQ-022 When BYPASS=0, reads SHALL return the pre-edge register contents.
REQ-023 When ZERO_REG=1:
- Writes to address 0 are discarded.
- Reads of address 0 return 0, with bypass suppressed.
- read_pending for address 0 is always 0.
- rsv_en to address 0 is ignored.
REQ-024 The pending flag SHALL change at the rising edge as follows:
- rsv_en=1 sets pending[rsv_addr].
- wr_en=1 clears pending[write_addr].
- If both target the same address in one cycle, set wins and the flag ends at 1.
- If they target different addresses, both updates apply.
REQ-025 read_pending port k SHALL equal pending[read_addr k] as registered; it is not bypassed by the same-cycle rsv_en or wr_en.
REQ-026 Multiple read ports SHALL be fully independent and may address the same register simultaneously.
REQ-027 Address arithmetic SHALL be unsigned ADDR_W bits with no wrap or out-of-range case, because DEPTH = 2**ADDR_W.
REQ-028 Reset, write and reserve SHALL all take effect only at rising edges; the design SHALL have no other clock and no latches.

Reset
REQ-029 While reset=1 at a rising edge, the design SHALL clear all registers to 0 and all pending flags to 0; wr_en and rsv_en are ignored that cycle.
REQ-030 After such a reset edge, every read_data port SHALL read 0 and read_pending SHALL be all 0.
- Bypass stays active combinationally during reset when wr_en=1, but the write is not stored.
REQ-031 A reset asserted in the same cycle as a write SHALL cancel that write; the next cycle reads 0 at write_addr.

Verification
REQ-032 Defaults, after reset: write 0xFFFFFFFF to addr 10 and 0x55555555 to addr 4; then read_addr = {4, 10} -> port0 = 0xFFFFFFFF, port1 = 0x55555555.
REQ-033 Byte enables: with reg 3 holding 0x11223344, write 0xAABBCCDD with write_be=0101 -> reg 3 reads 0x11BB33DD.
REQ-034 Bypass: BYPASS=1, write 0xDEADBEEF to addr 7 while read_addr0=7 -> port0 shows 0xDEADBEEF in the same cycle. With BYPASS=0 the same stimulus shows the old value until after the edge.
REQ-035 ZERO_REG=1: write 0x12345678 to addr 0 and rsv_en on addr 0 -> read of addr 0 = 0 and read_pending = 0.
REQ-036 Scoreboard:
- Reserve addr 5 -> read_pending = 1 from the next cycle.
- Write addr 5 -> flag is 0 after the edge.
- Simultaneous reserve and write on addr 5 -> flag remains 1.
REQ-037 Reset mid-operation: set reg 2 = 0x0000FFFF and pending[2] = 1, then reset=1 together with wr_en to addr 2 -> the next cycle reads 0 and the pending flag is 0.

Source files
------------

// File: rtl/reg_file_param.sv
// Parameterised register file: combinational multi-port reads, byte-enabled write
// with optional same-cycle forwarding, optional hardwired zero register, pending scoreboard.
module reg_file_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          write_addr,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [DATA_W/8-1:0]        write_be,
    input  logic [NUM_RD*ADDR_W-1:0]   read_addr,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [NUM_RD-1:0]          read_pending
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned NUM_BYTES = DATA_W / 8;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              wr_store;
    logic              rsv_take;

    // Value that the write would leave in the target register after byte merging.
    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_merge
        assign wr_data_d[b*8 +: 8] = write_be[b] ? write_data[b*8 +: 8]
                                                 : regs_q[write_addr][b*8 +: 8];
    end

    assign wr_store = wr_en && !((ZERO_REG == 1) && (write_addr == ADDR_W'(0)));
    assign rsv_take = rsv_en && !((ZERO_REG == 1) && (rsv_addr == ADDR_W'(0)));

    // Reserve is applied after the clear so a same-address reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[write_addr] = 1'b0;
        end
        if (rsv_take) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (wr_store) begin
                regs_q[write_addr] <= wr_data_d;
            end
            pend_q <= pend_d;
        end
    end

    // Read ports; the pending flag is deliberately not forwarded.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              fwd_hit;

        assign ra       = read_addr[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG == 1) && (ra == ADDR_W'(0));
        assign fwd_hit  = (BYPASS == 1) && wr_en && (ra == write_addr);

        assign read_data[k*DATA_W +: DATA_W] = zero_hit ? DATA_W'(0)
                                             : fwd_hit  ? wr_data_d
                                             : regs_q[ra];
        assign read_pending[k] = zero_hit ? 1'b0 : pend_q[ra];
    end

endmodule
